// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and sizing helpers for the sequential restoring divider.
//   div_state_t : controller states (IDLE, CALC, DONE)
//   CNT_W       : step-counter width for the default 8-bit divider
//   div_cnt_w() : step-counter width for any WIDTH
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Counter width able to hold 0..WIDTH for the default operand width.
  localparam int DIV_WIDTH_DEFAULT = 8;
  localparam int CNT_W             = $clog2(DIV_WIDTH_DEFAULT + 1);

  // Counter width able to hold 0..width for an arbitrary operand width.
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_i     : current partial remainder (always < divisor, so WIDTH bits)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor
//   rem_o     : partial remainder after this step
//   q_bit_o   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] divisor_ext;

  // Trial subtraction: keep the difference only when it does not go negative.
  always_comb begin
    trial       = {rem_i, bit_i};
    divisor_ext = {1'b0, divisor_i};
    q_bit_o     = (trial >= divisor_ext);
    if (q_bit_o) begin
      // The difference is below the divisor, so it always fits in WIDTH bits.
      rem_o = WIDTH'(trial - divisor_ext);
    end else begin
      // Not subtracting means trial < divisor, so its MSB is zero.
      rem_o = trial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on the operand and result sides.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (dividend, divisor)
//   out_valid / out_ready: result handshake (quotient, remainder, div_by_zero)
// A zero divisor skips the iteration and returns quotient = all ones,
// remainder = dividend, div_by_zero = 1.
// -----------------------------------------------------------------------------
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                    STEP_CNT_W = div_cnt_w(WIDTH);
  localparam logic [STEP_CNT_W-1:0] LAST_STEP  = STEP_CNT_W'(WIDTH - 1);

  div_state_t            state_q,       state_d;
  logic [STEP_CNT_W-1:0] count_q,       count_d;
  // Holds the dividend at start; quotient bits shift in from the LSB as
  // dividend bits shift out of the MSB.
  logic [WIDTH-1:0]      shreg_q,       shreg_d;
  logic [WIDTH-1:0]      rem_q,         rem_d;
  logic [WIDTH-1:0]      divisor_q,     divisor_d;
  logic                  in_ready_q,    in_ready_d;
  logic                  out_valid_q,   out_valid_d;
  logic [WIDTH-1:0]      quotient_q,    quotient_d;
  logic [WIDTH-1:0]      remainder_q,   remainder_d;
  logic                  div_by_zero_q, div_by_zero_d;

  logic [WIDTH-1:0]      step_rem;
  logic                  step_q_bit;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i     (rem_q),
    .bit_i     (shreg_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  // Next-state and next-output logic for the IDLE/CALC/DONE controller.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    shreg_d       = shreg_q;
    rem_d         = rem_q;
    divisor_d     = divisor_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          count_d    = '0;
          shreg_d    = dividend;
          rem_d      = '0;
          divisor_d  = divisor;
          in_ready_d = 1'b0;
          if (divisor == {WIDTH{1'b0}}) begin
            // Result is known at once; out_valid follows one edge later
            // from the DONE branch below.
            state_d       = DONE;
            quotient_d    = '1;
            remainder_d   = dividend;
            div_by_zero_d = 1'b1;
          end else begin
            state_d       = CALC;
            div_by_zero_d = 1'b0;
          end
        end else begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end
      end

      CALC: begin
        shreg_d = {shreg_q[WIDTH-2:0], step_q_bit};
        rem_d   = step_rem;
        count_d = count_q + STEP_CNT_W'(1);
        if (count_q == LAST_STEP) begin
          state_d     = DONE;
          quotient_d  = {shreg_q[WIDTH-2:0], step_q_bit};
          remainder_d = step_rem;
          out_valid_d = 1'b1;
        end else begin
          state_d = CALC;
        end
      end

      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      shreg_q       <= '0;
      rem_q         <= '0;
      divisor_q     <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      shreg_q       <= shreg_d;
      rem_q         <= rem_d;
      divisor_q     <= divisor_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider
// Directed self-checking bench for restoring_divider (WIDTH = 8): latency,
// divide-by-zero, corner operands, backpressure, mid-division reset, and a
// scoreboarded sweep with random handshake stalls.
// -----------------------------------------------------------------------------
module tb_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;

  restoring_divider #(
    .WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one operand pair while the DUT is idle and wait for out_valid.
  // lat counts edges after the accepting edge; saw_ready flags in_ready=1
  // at any point while the division was busy.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output bit saw_ready);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    lat       = 0;
    saw_ready = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) saw_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("timeout_out_valid", 32'(out_valid), 32'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  vec_t corners[5];

  logic [16:0] sb[$];
  int          got;
  int          lat;
  bit          saw_ready;
  bit          saw_valid;

  initial begin
    corners[0] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0};
    corners[1] = '{a: 8'd3,   b: 8'd200, q: 8'd0,   r: 8'd3};
    corners[2] = '{a: 8'd0,   b: 8'd9,   q: 8'd0,   r: 8'd0};
    corners[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0};
    corners[4] = '{a: 8'd128, b: 8'd2,   q: 8'd64,  r: 8'd0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = 8'd0;
    divisor   = 8'd0;

    // Reset state
    @(posedge clk); #1;
    check("rst_in_ready",  32'(in_ready),    32'd1);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_quotient",  32'(quotient),    32'd0);
    check("rst_remainder", 32'(remainder),   32'd0);
    check("rst_dbz",       32'(div_by_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 200/7, latency and in_ready low while busy
    run_div(8'd200, 8'd7, lat, saw_ready);
    check("t1_latency",  32'(lat),         32'd8);
    check("t1_in_ready", 32'(saw_ready),   32'd0);
    check("t1_quotient", 32'(quotient),    32'd28);
    check("t1_rem",      32'(remainder),   32'd4);
    check("t1_dbz",      32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    check("t1_idle_ready", 32'(in_ready),  32'd1);
    check("t1_idle_valid", 32'(out_valid), 32'd0);

    // 2: 5/0 then 9/3
    run_div(8'd5, 8'd0, lat, saw_ready);
    check("t2_latency",  32'(lat),         32'd1);
    check("t2_quotient", 32'(quotient),    32'd255);
    check("t2_rem",      32'(remainder),   32'd5);
    check("t2_dbz",      32'(div_by_zero), 32'd1);
    @(posedge clk); #1;
    run_div(8'd9, 8'd3, lat, saw_ready);
    check("t2b_quotient", 32'(quotient),    32'd3);
    check("t2b_rem",      32'(remainder),   32'd0);
    check("t2b_dbz",      32'(div_by_zero), 32'd0);
    @(posedge clk); #1;

    // 3: corner operands
    foreach (corners[i]) begin
      run_div(corners[i].a, corners[i].b, lat, saw_ready);
      check($sformatf("t3_q_%0d", i),   32'(quotient),    32'(corners[i].q));
      check($sformatf("t3_r_%0d", i),   32'(remainder),   32'(corners[i].r));
      check($sformatf("t3_dbz_%0d", i), 32'(div_by_zero), 32'd0);
      @(posedge clk); #1;
    end

    // 4: backpressure on 100/9
    out_ready = 1'b0;
    run_div(8'd100, 8'd9, lat, saw_ready);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_q",     32'(quotient),  32'd11);
      check("t4_hold_r",     32'(remainder), 32'd1);
      check("t4_hold_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_release_valid", 32'(out_valid), 32'd0);
    check("t4_release_ready", 32'(in_ready),  32'd1);

    // 5: reset during the 4th CALC cycle of 77/5
    dividend = 8'd77;
    divisor  = 8'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid),   32'd0);
    check("t5_rst_q",     32'(quotient),    32'd0);
    check("t5_rst_r",     32'(remainder),   32'd0);
    check("t5_rst_dbz",   32'(div_by_zero), 32'd0);
    check("t5_rst_ready", 32'(in_ready),    32'd1);
    @(negedge clk) rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("t5_no_result",  32'(saw_valid), 32'd0);
    check("t5_post_ready", 32'(in_ready),  32'd1);
    run_div(8'd77, 8'd5, lat, saw_ready);
    check("t5_q", 32'(quotient),  32'd15);
    check("t5_r", 32'(remainder), 32'd2);
    @(posedge clk); #1;

    // 6: operand sweep with random stalls on both handshakes
    got = 0;
    fork
      begin : driver
        for (int i = 0; i < 16; i++) begin
          for (int j = 0; j < 16; j++) begin
            int          a_i;
            int          b_i;
            int          wait_cyc;
            logic [16:0] exp_v;
            a_i = i * 17;
            b_i = (j == 0) ? 0 : j * 13 + 1;
            if (b_i == 0) exp_v = {1'b1, 8'hFF, 8'(a_i)};
            else          exp_v = {1'b0, 8'(a_i / b_i), 8'(a_i % b_i)};
            repeat ($urandom_range(0, 2)) begin
              in_valid = 1'b0;
              @(posedge clk); #1;
            end
            dividend = 8'(a_i);
            divisor  = 8'(b_i);
            in_valid = 1'b1;
            wait_cyc = 0;
            while (!in_ready && wait_cyc < 100) begin
              @(posedge clk); #1;
              wait_cyc++;
            end
            if (!in_ready) begin
              check("t6_drv_timeout", 32'(in_ready), 32'd1);
            end else begin
              sb.push_back(exp_v);
              @(posedge clk); #1;
            end
            in_valid = 1'b0;
          end
        end
      end
      begin : monitor
        int cyc;
        cyc = 0;
        while (got < 256 && cyc < 20000) begin
          @(posedge clk); #1;
          cyc++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              check("t6_unexpected_result", 32'(sb.size()), 32'd1);
            end else begin
              logic [16:0] e;
              e = sb.pop_front();
              check("t6_q",   32'(quotient),    32'(e[15:8]));
              check("t6_r",   32'(remainder),   32'(e[7:0]));
              check("t6_dbz", 32'(div_by_zero), 32'(e[16]));
            end
            got++;
          end
        end
      end
    join
    check("t6_result_count", 32'(got),       32'd256);
    check("t6_sb_empty",     32'(sb.size()), 32'd0);
    out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
